// File: rtl/rt_sched_pkg.sv
// Shared types and helpers for the ray frame scheduler.
package rt_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

    function automatic int frame_pixels(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

endpackage

// File: rtl/inflight_credit_counter.sv
// Tracks rays issued but not yet shaded; refuses to count below zero.
module inflight_credit_counter #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         at_limit,
    output logic         underflow
);

    logic dec_ok;

    assign underflow = dec && (count == '0);
    assign dec_ok    = dec && (count != '0);
    assign at_limit  = (count >= max);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({inc, dec_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Walks an H_RES x V_RES frame in raster order and issues one primary ray per
// pixel, throttled by FIFO backpressure and an in-flight credit limit.
module ray_frame_scheduler
    import rt_sched_pkg::*;
#(
    parameter int D_BITS       = 32,
    parameter int Q_BITS       = 10,
    parameter int H_RES        = 64,
    parameter int V_RES        = 48,
    parameter int FOCAL        = 64,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [2:0][D_BITS-1:0] origin_in,
    input  logic                          in_full,
    output logic signed [5:0][D_BITS-1:0] ray_out,
    output logic                          ray_wr_en,
    input  logic                          pixel_done,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          credit_err
);

    localparam int NPIX = frame_pixels(H_RES, V_RES);
    localparam int XW   = $clog2(H_RES);
    localparam int YW   = $clog2(V_RES);
    localparam int CW   = $clog2(NPIX + 1);
    localparam int IW   = $clog2(MAX_INFLIGHT + 1);

    sched_state_t state, state_nx;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] issued, completed;
    logic [IW-1:0] inflight;
    logic          at_limit, underflow, dec_ok, start_ok;

    logic signed [2:0][D_BITS-1:0] origin;
    logic signed [D_BITS-1:0]      dx, dy, dz;

    assign start_ok   = (state == IDLE) && start;
    assign dec_ok     = pixel_done && !underflow;
    assign ray_wr_en  = (state == ISSUE) && !in_full && !at_limit;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    inflight_credit_counter #(.W(IW)) u_credit (
        .clock     (clock),
        .reset     (reset),
        .inc       (ray_wr_en),
        .dec       (pixel_done),
        .max       (IW'(MAX_INFLIGHT)),
        .count     (inflight),
        .at_limit  (at_limit),
        .underflow (underflow)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // ISSUE leaves on the edge of the final write; DRAIN counts a completion
    // arriving on that same edge so the frame ends without an extra cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: if (ray_wr_en && issued == CW'(NPIX - 1)) state_nx = DRAIN;
            DRAIN: if (completed + CW'(dec_ok) == CW'(NPIX)) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            issued     <= '0;
            completed  <= '0;
            origin     <= '0;
            credit_err <= 1'b0;
        end else begin
            if (underflow) credit_err <= 1'b1;
            if (start_ok) begin
                x         <= '0;
                y         <= '0;
                issued    <= '0;
                completed <= '0;
                origin    <= origin_in;
            end else begin
                if (ray_wr_en) begin
                    issued <= issued + 1'b1;
                    if (x == XW'(H_RES - 1)) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                if (dec_ok) completed <= completed + 1'b1;
            end
        end
    end

    // Pixel-centred camera ray; y grows downward so dy flips sign.
    assign dx = (D_BITS'(x) - D_BITS'(H_RES / 2)) <<< Q_BITS;
    assign dy = (D_BITS'(V_RES / 2) - D_BITS'(y)) <<< Q_BITS;
    assign dz = (D_BITS'(0) - D_BITS'(FOCAL)) <<< Q_BITS;

    always_comb begin
        ray_out = '0;
        if (state == ISSUE) begin
            ray_out[2:0] = origin;
            ray_out[3]   = dx;
            ray_out[4]   = dy;
            ray_out[5]   = dz;
        end
    end

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed bench: 4x2 frame (credit 16) plus a 4x2 frame with a credit of 2.
module tb_ray_frame_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic                      start, in_full, pixel_done;
    logic signed [2:0][31:0]   origin_in;
    logic signed [5:0][31:0]   ray_out;
    logic                      ray_wr_en, busy, frame_done, credit_err;

    logic                      start_b, in_full_b, pixel_done_b;
    logic signed [2:0][31:0]   origin_b;
    logic signed [5:0][31:0]   ray_out_b;
    logic                      wr_b, busy_b, fd_b, ce_b;

    int checks = 0;
    int errors = 0;

    ray_frame_scheduler #(.H_RES(4), .V_RES(2), .MAX_INFLIGHT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .origin_in(origin_in),
        .in_full(in_full), .ray_out(ray_out), .ray_wr_en(ray_wr_en),
        .pixel_done(pixel_done), .busy(busy), .frame_done(frame_done),
        .credit_err(credit_err)
    );

    ray_frame_scheduler #(.H_RES(4), .V_RES(2), .MAX_INFLIGHT(2)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .origin_in(origin_b),
        .in_full(in_full_b), .ray_out(ray_out_b), .ray_wr_en(wr_b),
        .pixel_done(pixel_done_b), .busy(busy_b), .frame_done(fd_b),
        .credit_err(ce_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c;
        logic seen;
        logic [31:0] pend_dx, pend_dy;

        start = 0; in_full = 0; pixel_done = 0; origin_in = '0;
        start_b = 0; in_full_b = 0; pixel_done_b = 0; origin_b = '0;

        // reset state
        #12;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_wr",    32'(ray_wr_en), 0);
        chk("rst_cerr",  32'(credit_err), 0);
        chk("rst_ray",   32'(|ray_out), 0);
        @(negedge clock) reset = 0;

        // basic frame: 8 back-to-back writes
        @(negedge clock);
        origin_in[0] = 32'sd1024; origin_in[1] = 32'sd2048; origin_in[2] = 32'sd3072;
        start = 1;
        @(negedge clock);
        start = 0; origin_in = '0;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (k == 1) begin
                chk("first_ox", ray_out[0], 1024);
                chk("first_oy", ray_out[1], 2048);
                chk("first_oz", ray_out[2], 3072);
                chk("first_dx", ray_out[3], -2048);
                chk("first_dy", ray_out[4], 1024);
                chk("first_dz", ray_out[5], -65536);
            end
            if (k == 8) begin
                chk("last_dx", ray_out[3], 1024);
                chk("last_dy", ray_out[4], 0);
                chk("last_dz", ray_out[5], -65536);
            end
            if (ray_wr_en) n++;
            @(negedge clock);
        end
        #1;
        chk("t1_writes", n, 8);
        chk("drain_wr", 32'(ray_wr_en), 0);
        chk("drain_busy", 32'(busy), 1);
        chk("drain_ray", 32'(|ray_out), 0);

        repeat (8) @(negedge clock);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            pixel_done = 1;
            #1;
            if (frame_done) seen = 1;
            @(negedge clock);
        end
        pixel_done = 0;
        #1;
        chk("early_fdone", 32'(seen), 0);
        chk("fdone_pulse", 32'(frame_done), 1);
        chk("fdone_busy", 32'(busy), 1);
        @(negedge clock);
        #1;
        chk("fdone_clear", 32'(frame_done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("t1_cerr", 32'(credit_err), 0);

        // stall on in_full for cycles 3..5, plus an ignored start in cycle 2
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        n = 0; c = 0; seen = 0; pend_dx = '0; pend_dy = '0;
        while (n < 8 && c < 30) begin
            c++;
            if (c > 1) @(negedge clock);
            in_full = (c >= 3 && c <= 5);
            start = (c == 2);
            #1;
            if (c == 3) begin
                pend_dx = ray_out[3];
                pend_dy = ray_out[4];
                chk("pend_dx", pend_dx, 0);
                chk("pend_dy", pend_dy, 1024);
            end
            if (c >= 3 && c <= 5 && ray_wr_en) seen = 1;
            if (c == 6) begin
                chk("resume_wr", 32'(ray_wr_en), 1);
                chk("resume_dx", ray_out[3], pend_dx);
                chk("resume_dy", ray_out[4], pend_dy);
            end
            if (ray_wr_en) n++;
        end
        chk("stall_no_wr", 32'(seen), 0);
        chk("t2_writes", n, 8);
        chk("t2_last_cycle", c, 11);
        @(negedge clock);
        in_full = 0; start = 0;
        for (int k = 0; k < 8; k++) begin
            pixel_done = 1;
            @(negedge clock);
        end
        pixel_done = 0;
        seen = 0;
        for (int k = 0; k < 5 && !seen; k++) begin
            #1;
            if (frame_done) seen = 1;
            else @(negedge clock);
        end
        chk("t2_fdone", 32'(seen), 1);
        repeat (2) @(negedge clock);
        #1;
        chk("t2_idle", 32'(busy), 0);

        // credit limit of 2
        @(negedge clock) start_b = 1;
        @(negedge clock) start_b = 0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (wr_b) n++;
            @(negedge clock);
        end
        chk("lim_writes", n, 2);
        pixel_done_b = 1;
        #1;
        chk("lim_held", 32'(wr_b), 0);
        @(negedge clock) pixel_done_b = 0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (wr_b) n++;
            @(negedge clock);
        end
        chk("lim_refill", n, 1);
        chk("lim_cerr", 32'(ce_b), 0);

        // pixel_done while idle
        pixel_done = 1;
        @(negedge clock) pixel_done = 0;
        #1;
        chk("idle_cerr", 32'(credit_err), 1);
        chk("idle_stay", 32'(busy), 0);
        repeat (3) @(negedge clock);
        #1;
        chk("cerr_sticky", 32'(credit_err), 1);

        // reset in the middle of ISSUE
        @(negedge clock);
        origin_in[0] = 32'sd5120; start = 1;
        @(negedge clock) start = 0;
        repeat (3) @(negedge clock);
        #1;
        chk("pre_rst_wr", 32'(ray_wr_en), 1);
        #2 reset = 1;
        #1;
        chk("mrst_wr", 32'(ray_wr_en), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_ray", 32'(|ray_out), 0);
        chk("mrst_cerr", 32'(credit_err), 0);
        @(negedge clock) reset = 0;
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        #1;
        chk("restart_wr", 32'(ray_wr_en), 1);
        chk("restart_dx", ray_out[3], -2048);
        chk("restart_dy", ray_out[4], 1024);
        chk("restart_ox", ray_out[0], 5120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ray_frame_scheduler.md
# ray_frame_scheduler

Frame-level sequencer that drives the ray-tracing pipeline. On `start` it latches a camera origin, walks every pixel of an H_RES × V_RES frame in raster order, and pushes one primary ray per pixel into the input ray FIFO. A credit counter caps the number of rays in flight, and completed pixels are counted from the shader's write strobe. `frame_done` pulses once every pixel of the frame has been shaded.

## Interface
- `D_BITS`, 32: data word width (signed fixed point).
- `Q_BITS`, 10: fractional bits.
- `H_RES`, 64: pixels per row (≥2, even).
- `V_RES`, 48: rows per frame (≥2, even).
- `FOCAL`, 64: image-plane distance, integer units.
- `MAX_INFLIGHT`, 16: maximum rays issued but not yet shaded (≥1).

- `clock`  in  1: sole clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin a frame; sampled only in IDLE.
- `origin_in`  in  signed [D_BITS-1:0] [2:0]: camera origin; latched on accepted `start`.
- `in_full`  in  1: input ray FIFO full.
- `ray_out`  out  signed [D_BITS-1:0] [5:0]: [2:0] origin, [5:3] direction.
- `ray_wr_en`  out  1: write strobe to the input ray FIFO.
- `pixel_done`  in  1: one-cycle pulse per shaded pixel (shader write strobe).
- `busy`  out  1: state ≠ IDLE.
- `frame_done`  out  1: one-cycle pulse at frame completion.
- `credit_err`  out  1: sticky; `pixel_done` arrived while in-flight count was 0.

## Operation
- **States:**
  - IDLE → ISSUE on `start`; latches origin and clears x, y, issued, completed.
  - ISSUE → DRAIN when issued = H_RES·V_RES.
  - DRAIN → DONE when completed = H_RES·V_RES.
  - DONE → IDLE unconditionally.
- **Issue rule (combinational):** `ray_wr_en` = (state = ISSUE) ∧ ¬`in_full` ∧ (inflight < MAX_INFLIGHT).
- **On each write:**
  - x increments; on x = H_RES−1, x wraps to 0 and y increments.
  - issued and inflight increment.
- **Direction (signed, sign-extended to D_BITS, then `<<< Q_BITS`):**
  - dx = x − H_RES/2
  - dy = V_RES/2 − y
  - dz = −FOCAL
- **Ray output:** `ray_out` = {dz, dy, dx, oz, oy, ox} from index 5 down to 0 when in ISSUE; all zeros otherwise.
- **Completion:** `pixel_done` with inflight > 0 decrements inflight and increments completed.
  - With inflight = 0: ignored, and `credit_err` sets (cleared only by reset).
  - `pixel_done` in IDLE or DONE with inflight = 0 also sets `credit_err`.
- **Simultaneous write and `pixel_done`:** inflight unchanged; issued and completed both increment.
- **`start` outside IDLE:** ignored. `origin_in` changes after latch have no effect.
- **Counter widths:**
  - x: $clog2(H_RES)
  - y: $clog2(V_RES)
  - issued, completed: $clog2(H_RES·V_RES+1)
  - inflight: $clog2(MAX_INFLIGHT+1)

## Timing
- **Reset values:**
  - state IDLE
  - `busy` 0, `frame_done` 0, `ray_wr_en` 0, `credit_err` 0
  - `ray_out` all 0
  - all counters 0, origin registers 0
- **Start latency:** `start` high at edge N → ISSUE from N; first `ray_wr_en` possible in cycle N+1.
- **Throughput:** one ray per cycle while unthrottled.
- **`in_full` stall:** takes effect the same cycle; no ray is lost or duplicated. `ray_out` holds until written.
- **Last write:** at edge M, state = DRAIN from M. If all pixels were already shaded, the completion check happens in DRAIN on the next edge.
- **Frame end:** completion reached at edge K → DONE from K; `frame_done` high for cycle K..K+1, IDLE at K+1. A new `start` is accepted at K+1 or later.
- **Reset mid-frame:** immediate return to IDLE and `ray_wr_en` drops asynchronously. Downstream flush is the system's responsibility.

## Structure
- Package `rt_sched_pkg`:
  - state enum `sched_state_t` {IDLE, ISSUE, DRAIN, DONE}
  - localparam helper for frame pixel count
- One sub-module, `inflight_credit_counter`:
  - inputs: inc, dec, max
  - outputs: count, at_limit, underflow
- The top level holds the FSM, raster counters and direction math.

## Test plan
- H=4, V=2, MAX=16, `in_full`=0, origin (1,2,3)<<10, `start` at cycle 0 → 8 writes in cycles 1–8.
  - First dir = (−2048, 1024, −65536); last dir = (1024, 0, −65536).
- Same config, `pixel_done` pulses at cycles 20–27 → `frame_done` high exactly one cycle after the edge at 27; `busy` low afterwards.
- MAX=2, no `pixel_done` → exactly 2 writes, then `ray_wr_en` stays low. One `pixel_done` → exactly one further write.
- `in_full` held high for cycles 3–5 → no writes in those cycles. The ray pending at cycle 3 is written at cycle 6 with unchanged `ray_out`.
- `pixel_done` in IDLE after reset → `credit_err`=1 and stays 1. `start` during ISSUE → ignored, counters unaffected.
- `reset` asserted mid-ISSUE → `ray_wr_en`, `busy` and `ray_out` go to 0 immediately. A fresh `start` restarts at pixel (0,0).
